// File: rtl/roi_serial_ctrl_pkg.sv
// Shared types and helpers for the serial ROI harness controller.
package roi_serial_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StStrobe,
        StWait,
        StCapture,
        StDone
    } state_e;

    // Width of the single down-counter: enough to hold the largest phase length.
    function automatic int unsigned cnt_width(int unsigned din_n, int unsigned dout_n,
                                              int unsigned do_lat);
        int unsigned m;
        m = din_n;
        if (dout_n > m) m = dout_n;
        if (do_lat > m) m = do_lat;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/roi_serial_ctrl_if.sv
// Request/response handshake bundle between host and the ROI serial controller.
interface roi_serial_ctrl_if #(
    parameter int unsigned DIN_N  = 256,
    parameter int unsigned DOUT_N = 256
);
    logic              in_valid;
    logic              in_ready;
    logic [DIN_N-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DOUT_N-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/roi_serial_ctrl.sv
// Shifts one request word MSB-first onto di, strobes the harness, then shifts the
// harness response back in from do_i and presents it on the response handshake.
module roi_serial_ctrl
    import roi_serial_pkg::*;
#(
    parameter int unsigned DIN_N  = 256,
    parameter int unsigned DOUT_N = 256,
    parameter int unsigned DO_LAT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    roi_serial_ctrl_if.slave        bus,
    output logic                    di,
    output logic                    stb,
    input  logic                    do_i,
    output logic                    busy
);

    localparam int unsigned CW = cnt_width(DIN_N, DOUT_N, DO_LAT);
    localparam int unsigned WaitLen = (DO_LAT > 0) ? DO_LAT - 1 : 0;
    localparam logic [CW-1:0] ShiftLoad = CW'(DIN_N - 1);
    localparam logic [CW-1:0] WaitLoad  = CW'(WaitLen);
    localparam logic [CW-1:0] CapLoad   = CW'(DOUT_N - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DIN_N-1:0]  sh_q, sh_d;
    logic [DOUT_N-1:0] cap_q, cap_d;
    logic              di_q, di_d;
    logic              stb_q, stb_d;
    logic              ov_q, ov_d;
    logic              accept;
    logic              cnt_zero;

    assign accept   = (state_q == StIdle) && bus.in_valid;
    assign cnt_zero = (cnt_q == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic: every phase ends when the counter reaches zero.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (accept) state_d = StShift;
            StShift:   if (cnt_zero) state_d = StStrobe;
            StStrobe:  state_d = (DO_LAT == 0) ? StCapture : StWait;
            StWait:    if (cnt_zero) state_d = StCapture;
            StCapture: if (cnt_zero) state_d = StDone;
            StDone:    if (bus.out_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Datapath next values; di/stb are computed one cycle ahead so they leave flops.
    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        cap_d = cap_q;
        di_d  = 1'b0;
        stb_d = 1'b0;
        ov_d  = ov_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    di_d  = bus.in_data[DIN_N-1];
                    sh_d  = bus.in_data << 1;
                    cnt_d = ShiftLoad;
                end
            end
            StShift: begin
                if (cnt_zero) begin
                    stb_d = 1'b1;
                end else begin
                    di_d  = sh_q[DIN_N-1];
                    sh_d  = sh_q << 1;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StStrobe: cnt_d = (DO_LAT == 0) ? CapLoad : WaitLoad;
            StWait:   cnt_d = cnt_zero ? CapLoad : cnt_q - 1'b1;
            StCapture: begin
                cap_d = {cap_q[DOUT_N-2:0], do_i};
                if (cnt_zero) ov_d = 1'b1;
                else          cnt_d = cnt_q - 1'b1;
            end
            StDone:  if (bus.out_ready) ov_d = 1'b0;
            default: ;
        endcase
    end

    // Datapath registers; reset discards any partial operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sh_q  <= '0;
            cap_q <= '0;
            di_q  <= 1'b0;
            stb_q <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
            cap_q <= cap_d;
            di_q  <= di_d;
            stb_q <= stb_d;
            ov_q  <= ov_d;
        end
    end

    assign di            = di_q;
    assign stb           = stb_q;
    assign busy          = (state_q != StIdle);
    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = ov_q;
    assign bus.out_data  = cap_q;

endmodule

// File: tb/tb_roi_serial_ctrl.sv
// Three controllers, each behind a loopback harness model:
// lane 0: N=8 DO_LAT=0, lane 1: N=8 DO_LAT=2 (two flops on do), lane 2: N=256 DO_LAT=0.
module tb_roi_serial_ctrl;

    typedef struct {
        logic [255:0] data;
        int           lat;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    logic [2:0]         iv = '0;
    logic [2:0]         ordy = '0;
    logic [255:0]       idata [3];
    logic [2:0]         ir, ov, di, stb, busy;
    logic [2:0][255:0]  od_p;
    item_t              exp_q [3][$];

    int n_pass = 0;
    int n_total = 0;

    task automatic check(string name, logic [255:0] act, logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_lane
        localparam int unsigned LN = (g == 2) ? 256 : 8;
        localparam int unsigned LL = (g == 1) ? 2 : 0;

        roi_serial_ctrl_if #(.DIN_N(LN), .DOUT_N(LN)) bus ();
        logic          di_w, stb_w, busy_w, do_w;
        logic [LN-1:0] h_din, h_dout;
        logic [1:0]    dly;

        assign bus.in_valid  = iv[g];
        assign bus.in_data   = idata[g][LN-1:0];
        assign bus.out_ready = ordy[g];
        assign ir[g]   = bus.in_ready;
        assign ov[g]   = bus.out_valid;
        assign di[g]   = di_w;
        assign stb[g]  = stb_w;
        assign busy[g] = busy_w;
        assign od_p[g] = 256'(bus.out_data);

        // Loopback harness: din shifts in from di, stb copies din into dout, dout shifts out.
        always @(posedge clk) begin
            if (rst) begin
                h_din  <= '0;
                h_dout <= '0;
                dly    <= '0;
            end else begin
                h_din  <= {h_din[LN-2:0], di_w};
                h_dout <= stb_w ? h_din : (h_dout << 1);
                dly    <= {dly[0], h_dout[LN-1]};
            end
        end
        assign do_w = (LL == 0) ? h_dout[LN-1] : dly[1];

        roi_serial_ctrl #(.DIN_N(LN), .DOUT_N(LN), .DO_LAT(LL)) u_dut (
            .clk  (clk),
            .rst  (rst),
            .bus  (bus),
            .di   (di_w),
            .stb  (stb_w),
            .do_i (do_w),
            .busy (busy_w)
        );

        int           e0 = -100000;
        int           stb_cnt = 0;
        logic [255:0] di_seq = '0;
        logic         ov_prev = 1'b0;
        item_t        cur;
        logic [255:0] mask;
        assign mask = {256{1'b1}} >> (256 - LN);

        // Edge number of the accepting handshake.
        initial forever begin
            @(posedge clk);
            if (!rst && bus.in_valid && bus.in_ready) e0 = ecnt + 1;
        end

        // Monitor: collect di/stb per op, compare against scoreboard on out_valid.
        initial forever begin
            @(negedge clk);
            if (ecnt == e0) stb_cnt = 0;
            if (ecnt >= e0 && ecnt < e0 + int'(LN)) di_seq = {di_seq[254:0], di_w};
            if (stb_w) begin
                stb_cnt++;
                check($sformatf("stb_cycle[%0d]", g), 256'(ecnt - e0), 256'(LN));
            end
            if (bus.out_valid && !ov_prev) begin
                if (exp_q[g].size() == 0) begin
                    check($sformatf("unexpected_out[%0d]", g), 1, 0);
                end else begin
                    cur = exp_q[g].pop_front();
                    check($sformatf("out_data[%0d]", g), od_p[g], cur.data);
                    check($sformatf("latency[%0d]", g), 256'(ecnt - e0), 256'(cur.lat));
                    check($sformatf("di_seq[%0d]", g), di_seq & mask, cur.data);
                    check($sformatf("stb_count[%0d]", g), 256'(stb_cnt), 1);
                end
            end else if (bus.out_valid) begin
                check($sformatf("out_hold[%0d]", g), od_p[g], cur.data);
            end
            ov_prev = bus.out_valid;
        end
    end

    task automatic send(int ln, logic [255:0] d, int lat);
        item_t it;
        int    n;
        it.data = d;
        it.lat  = lat;
        exp_q[ln].push_back(it);
        idata[ln] = d;
        iv[ln]    = 1'b1;
        n = 0;
        while (!ir[ln] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", ir[ln], 1);
        @(negedge clk);
        iv[ln] = 1'b0;
    endtask

    task automatic wait_idle(int ln);
        int n;
        n = 0;
        while ((busy[ln] || ov[ln]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", busy[ln], 0);
    endtask

    task automatic wait_ov(int ln);
        int n;
        n = 0;
        while (!ov[ln] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_wait", ov[ln], 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] pat;
        logic [31:0]  x;
        int           n;
        for (int i = 0; i < 3; i++) idata[i] = '0;
        x = 32'h1;
        for (int i = 0; i < 256; i++) begin
            x      = {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
            pat[i] = x[0];
        end

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_in_ready", ir[i], 1);
            check("rst_busy", busy[i], 0);
            check("rst_out_valid", ov[i], 0);
            check("rst_di", di[i], 0);
            check("rst_stb", stb[i], 0);
            check("rst_out_data", od_p[i], 0);
        end

        // Basic loopback, N=8.
        ordy[0] = 1'b1;
        send(0, 256'hA5, 17);
        wait_idle(0);

        // N=256 LFSR pattern.
        ordy[2] = 1'b1;
        send(2, pat, 513);
        wait_idle(2);

        // Two extra flops on do.
        ordy[1] = 1'b1;
        send(1, 256'h3C, 19);
        wait_idle(1);

        // Back-to-back with out_ready high.
        send(0, 256'h01, 17);
        send(0, 256'h80, 17);
        wait_idle(0);

        // Response held off for 5 cycles while a new request waits.
        ordy[0] = 1'b0;
        send(0, 256'h5A, 17);
        wait_ov(0);
        begin
            item_t it;
            it.data = 256'hC3;
            it.lat  = 17;
            exp_q[0].push_back(it);
        end
        idata[0] = 256'hC3;
        iv[0]    = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("held_in_ready", ir[0], 0);
            check("held_busy", busy[0], 1);
            check("held_out_valid", ov[0], 1);
        end
        ordy[0] = 1'b1;
        n = 0;
        while (!ir[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("held_accept", ir[0], 1);
        @(negedge clk);
        iv[0] = 1'b0;
        wait_idle(0);

        // Reset in the middle of CAPTURE.
        send(0, 256'hFF, 17);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy[0], 0);
        check("midrst_out_valid", ov[0], 0);
        check("midrst_di", di[0], 0);
        check("midrst_stb", stb[0], 0);
        check("midrst_out_data", od_p[0], 0);
        exp_q[0].delete();
        send(0, 256'h0F, 17);
        wait_idle(0);

        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) check("queue_empty", 256'(exp_q[i].size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
